// File: rtl/mult_pkg.sv
// Shared definitions for the 4x4 multiplier datapath: operand-half width,
// step count and the recombiner FSM encoding.
package mult_pkg;
  localparam int HALF_W_DEFAULT = 2;
  localparam int STEPS          = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;
endpackage

// File: rtl/pp_shift_add.sv
// Combinational shift-accumulate of one partial product: the partial product
// is weighted by HALF_W * (sel_a + sel_b) and added to the running sum.
module pp_shift_add #(
  parameter int HALF_W = mult_pkg::HALF_W_DEFAULT
) (
  input  logic [4*HALF_W-1:0] acc,
  input  logic [2*HALF_W-1:0] pp,
  input  logic                sel_a,
  input  logic                sel_b,
  output logic [4*HALF_W-1:0] acc_next
);
  localparam int PP_W  = 2 * HALF_W;
  localparam int OUT_W = 4 * HALF_W;

  logic [OUT_W-1:0] pp_ext_s;
  logic [OUT_W-1:0] pp_shifted_s;

  // Weight the zero-extended partial product by its half-pair position.
  always_comb begin
    pp_ext_s     = {{(OUT_W-PP_W){1'b0}}, pp};
    pp_shifted_s = pp_ext_s;
    case ({sel_a, sel_b})
      2'b00:        pp_shifted_s = pp_ext_s;
      2'b01, 2'b10: pp_shifted_s = pp_ext_s << HALF_W;
      2'b11:        pp_shifted_s = pp_ext_s << (2 * HALF_W);
      default:      pp_shifted_s = pp_ext_s;
    endcase
    acc_next = acc + pp_shifted_s;
  end
endmodule

// File: rtl/product_assembler.sv
// Steps a shared 2x2 multiplier through the four operand half-pairs and
// shift-accumulates the accepted partial products into the full product.
module product_assembler
  import mult_pkg::*;
#(
  parameter int HALF_W = HALF_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                pp_valid,
  input  logic [2*HALF_W-1:0] pp,
  output logic                pp_ready,
  output logic                sel_a,
  output logic                sel_b,
  output logic                busy,
  output logic                done,
  output logic [4*HALF_W-1:0] product
);
  localparam int OUT_W = 4 * HALF_W;
  localparam logic [1:0] LAST_IDX = 2'(STEPS - 1);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic             pp_ready_q, pp_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [OUT_W-1:0] acc_sum_s;

  pp_shift_add #(.HALF_W(HALF_W)) u_shift_add (
    .acc      (acc_q),
    .pp       (pp),
    .sel_a    (idx_q[1]),
    .sel_b    (idx_q[0]),
    .acc_next (acc_sum_s)
  );

  // Next-state, accumulator and index update; flag outputs follow the next state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = {OUT_W{1'b0}};
          idx_d   = 2'd0;
          state_d = COLLECT;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (pp_valid) begin
          acc_d = acc_sum_s;
          idx_d = idx_q + 2'd1;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pp_ready_d = (state_d == COLLECT);
    busy_d     = (state_d == COLLECT);
    done_d     = (state_d == DONE);
  end

  // State and registered outputs; reset discards any partial sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      acc_q      <= {OUT_W{1'b0}};
      pp_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      pp_ready_q <= pp_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign pp_ready = pp_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sel_a    = idx_q[1];
  assign sel_b    = idx_q[0];
  assign product  = acc_q;
endmodule

// File: tb/tb_product_assembler.sv
// Directed bench for product_assembler: expected products are queued at start
// and compared when done pulses; handshake, selects and timing checked inline.
module tb_product_assembler;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pp_valid;
  logic [3:0] pp;
  logic       pp_ready;
  logic       sel_a;
  logic       sel_b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];

  product_assembler dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pp_valid (pp_valid),
    .pp       (pp),
    .pp_ready (pp_ready),
    .sel_a    (sel_a),
    .sel_b    (sel_b),
    .busy     (busy),
    .done     (done),
    .product  (product)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Partial product the upstream 2x2 multiplier would return for a given step.
  function automatic logic [3:0] half_pp(input logic [3:0] a, input logic [3:0] b, input int step);
    logic [1:0] ah;
    logic [1:0] bh;
    ah = step[1] ? a[3:2] : a[1:0];
    bh = step[0] ? b[3:2] : b[1:0];
    return {2'b00, ah} * {2'b00, bh};
  endfunction

  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input int stall_step, input int stall_len, input int restart_step);
    int         cyc;
    logic [7:0] held;
    logic [7:0] exp_p;
    start = 1'b1;
    exp_q.push_back({4'd0, a} * {4'd0, b});
    tick;
    start = 1'b0;
    cyc   = 2;
    chk("busy_collect", busy, 1);
    chk("product_clear", product, 0);
    for (int s = 0; s < 4; s++) begin
      if (s == stall_step) begin
        held = product;
        for (int k = 0; k < stall_len; k++) begin
          pp_valid = 1'b0;
          pp       = 4'hF;
          tick;
          cyc++;
          chk("stall_product", product, held);
          chk("stall_sel", {sel_a, sel_b}, s[1:0]);
          chk("stall_ready", pp_ready, 1);
        end
      end
      chk("sel", {sel_a, sel_b}, s[1:0]);
      chk("pp_ready", pp_ready, 1);
      chk("done_early", done, 0);
      pp       = half_pp(a, b, s);
      pp_valid = 1'b1;
      start    = (s == restart_step);
      tick;
      cyc++;
    end
    pp_valid = 1'b0;
    start    = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_cycle", cyc, 6 + stall_len);
    exp_p = exp_q.pop_front();
    chk("product", product, exp_p);
    chk("ready_done", pp_ready, 0);
    chk("busy_done", busy, 0);
    chk("sel_wrap", {sel_a, sel_b}, 0);
    tick;
    chk("done_single", done, 0);
    chk("busy_idle", busy, 0);
    chk("product_hold", product, exp_p);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    pp_valid = 1'b0;
    pp       = 4'd0;
    #1;
    chk("reset_outputs", {product, done, busy, pp_ready, sel_a, sel_b}, 0);
    tick;
    rst = 1'b0;
    tick;

    // pp_valid in IDLE must not touch the accumulator.
    for (int i = 0; i < 3; i++) begin
      pp_valid = 1'b1;
      pp       = 4'd9;
      tick;
      chk("idle_product", product, 0);
      chk("idle_ready", pp_ready, 0);
    end
    pp_valid = 1'b0;

    run_op(4'd10, 4'd11, -1, 0, -1);
    tick;
    tick;
    chk("product_hold_idle", product, 8'd110);

    run_op(4'd15, 4'd15, 2, 3, -1);
    run_op(4'd6, 4'd9, -1, 0, 2);
    run_op(4'd3, 4'd2, -1, 0, -1);

    // Reset mid-operation after two accepts.
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int s = 0; s < 2; s++) begin
      pp       = half_pp(4'd10, 4'd11, s);
      pp_valid = 1'b1;
      tick;
    end
    pp_valid = 1'b0;
    chk("partial_sum", product, 8'd22);
    chk("partial_sel", {sel_a, sel_b}, 2'b10);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_outputs", {product, done, busy, pp_ready, sel_a, sel_b}, 0);
    #2;
    rst = 1'b0;
    tick;
    chk("post_reset_idle", {busy, pp_ready, product}, 0);

    run_op(4'd5, 4'd7, -1, 0, -1);
    run_op(4'd9, 4'd14, -1, 0, -1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
